// File: rtl/bram_pkg.sv
// Shared types and default geometry for the dual-port NTT coefficient RAM
// with built-in clear engine.
package bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int BRAM_DW = 18;
  localparam int BRAM_AW = 11;

endpackage : bram_pkg

// File: rtl/bram_clr_ctrl.sv
// Clear-sweep controller: owns the CLEAR/READY FSM, the sweep counter and the
// ready flag, and muxes the sweep or the user onto the single RAM write port.
module bram_clr_ctrl
  import bram_pkg::*;
#(
  parameter int             DW        = BRAM_DW,
  parameter int             AW        = BRAM_AW,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_din,
  output logic          ready,
  output logic          eff_we,
  output logic [AW-1:0] eff_addr,
  output logic [DW-1:0] eff_din
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        // clr is deliberately not looked at here: a sweep is never restarted by clr.
        cnt_d = cnt_q + AW'(1);
        if (&cnt_q) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      ST_READY: begin
        if (clr) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
          ready_d = 1'b0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_CLEAR;
        ready_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    eff_we   = 1'b0;
    eff_addr = wr_addr;
    eff_din  = wr_din;
    if (state_q == ST_CLEAR) begin
      eff_we   = 1'b1;
      eff_addr = cnt_q;
      eff_din  = CLEAR_VAL;
    end else begin
      // A clr in the same cycle as a user write drops the write.
      eff_we = wr_en && !clr;
    end
  end

  assign ready = ready_q;

endmodule : bram_clr_ctrl

// File: rtl/bram_dp_clr.sv
// Parametrised simple-dual-port RAM with registered addresses, write-side
// readback and a clear engine. Optional output registers: BRAM_DP_OUTREG_EN.
module bram_dp_clr
  import bram_pkg::*;
#(
  parameter int             DW        = BRAM_DW,
  parameter int             AW        = BRAM_AW,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] wr_din,
  output logic [DW-1:0] wr_dout,
  output logic [DW-1:0] rd_dout,
  output logic          ready
);

  localparam int DEPTH = 2 ** AW;

  logic          eff_we;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_din;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_addr_p0, rd_addr_p0;
  logic [DW-1:0] wr_rdata_p0, rd_rdata_p0;

  bram_clr_ctrl #(
    .DW        (DW),
    .AW        (AW),
    .CLEAR_VAL (CLEAR_VAL)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_din   (wr_din),
    .ready    (ready),
    .eff_we   (eff_we),
    .eff_addr (eff_addr),
    .eff_din  (eff_din)
  );

  always_ff @(posedge clk) begin
    if (eff_we) begin
      mem[eff_addr] <= eff_din;
    end
  end

  // Stage p0: address registers load every edge, independent of ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_p0 <= '0;
      rd_addr_p0 <= '0;
    end else begin
      wr_addr_p0 <= wr_addr;
      rd_addr_p0 <= rd_addr;
    end
  end

  // Reading after the edge from the already-updated array gives write-first.
  assign wr_rdata_p0 = ready ? mem[wr_addr_p0] : '0;
  assign rd_rdata_p0 = ready ? mem[rd_addr_p0] : '0;

`ifdef BRAM_DP_OUTREG_EN
  logic [DW-1:0] wr_dout_p1, rd_dout_p1;

  // Stage p1: optional output registers, fed from the already-masked data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_dout_p1 <= '0;
      rd_dout_p1 <= '0;
    end else begin
      wr_dout_p1 <= wr_rdata_p0;
      rd_dout_p1 <= rd_rdata_p0;
    end
  end

  assign wr_dout = wr_dout_p1;
  assign rd_dout = rd_dout_p1;
`else
  assign wr_dout = wr_rdata_p0;
  assign rd_dout = rd_rdata_p0;
`endif

endmodule : bram_dp_clr

// File: tb/tb_bram_dp_clr.sv
// Self-checking bench for bram_dp_clr (AW=4, DW=18, CLEAR_VAL=18'h2AAAA) using
// an array model of the RAM; adapts read latency to BRAM_DP_OUTREG_EN.
module tb_bram_dp_clr;

  localparam int            DW    = 18;
  localparam int            AW    = 4;
  localparam int            DEPTH = 16;
  localparam logic [DW-1:0] CV    = 18'h2AAAA;
`ifdef BRAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_din = '0;
  logic [DW-1:0] wr_dout, rd_dout;
  logic          ready;

  logic [DW-1:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  bram_dp_clr #(.DW(DW), .AW(AW), .CLEAR_VAL(CV)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .wr_din  (wr_din),
    .wr_dout (wr_dout),
    .rd_dout (rd_dout),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // User write through the port; the model only changes if the RAM is ready.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_din = d;
    if (ready) model[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [AW-1:0] a);
    rd_addr = a; wr_addr = a; wr_en = 1'b0;
    repeat (LAT) tick();
    chk({tag, "_rd"}, rd_dout, model[a]);
    chk({tag, "_wr"}, wr_dout, model[a]);
  endtask

  // Called right after the edge that starts a sweep (rst edge or clr edge).
  // ready must stay low for exactly DEPTH samples, and outputs read 0, while
  // random user writes, address changes and clr pulses are thrown at it.
  task automatic sweep_check(input string tag, input bit kick_is_rst);
    for (int i = 0; i < DEPTH; i++) begin
      chk({tag, "_ready_low"}, {{(DW-1){1'b0}}, ready}, '0);
      if (kick_is_rst || i >= LAT - 1) begin
        chk({tag, "_rd_zero"}, rd_dout, '0);
        chk({tag, "_wr_zero"}, wr_dout, '0);
      end
      wr_en   = 1'($urandom_range(0, 1));
      wr_din  = DW'($urandom);
      wr_addr = AW'($urandom);
      rd_addr = AW'($urandom);
      clr     = 1'($urandom_range(0, 1));
      tick();
    end
    clr = 1'b0; wr_en = 1'b0;
    chk({tag, "_ready_high"}, {{(DW-1){1'b0}}, ready}, {{(DW-1){1'b0}}, 1'b1});
    for (int a = 0; a < DEPTH; a++) model[a] = CV;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Initial sweep, then fill the RAM with random data through the port.
    pulse_rst();
    sweep_check("init_sweep", 1'b1);
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), DW'($urandom));
    check_read("preload", AW'($urandom));

    // Scenario 1: rst over random contents sweeps every word to CLEAR_VAL.
    pulse_rst();
    sweep_check("s1_sweep", 1'b1);
    for (int a = 0; a < DEPTH; a++) check_read("s1_clear", AW'(a));

    // Scenario 2: plain writes then reads.
    do_write(4'd3, 18'h12345);
    do_write(4'd7, 18'h3FFFF);
    check_read("s2_a3", 4'd3);
    chk("s2_a3_const", rd_dout, 18'h12345);
    check_read("s2_a7", 4'd7);
    chk("s2_a7_const", rd_dout, 18'h3FFFF);

    // Scenario 3: write and read the same address in one cycle.
    check_read("s3_pre", 4'd5);
    wr_en = 1'b1; wr_addr = 4'd5; wr_din = 18'h00ABC; rd_addr = 4'd5;
    model[5] = 18'h00ABC;
    tick();
    wr_en = 1'b0;
    repeat (LAT - 1) tick();
    chk("s3_wf_rd", rd_dout, 18'h00ABC);
    chk("s3_wf_wr", wr_dout, 18'h00ABC);

    // Scenario 4: clr together with a write; the write is dropped.
    do_write(4'd2, 18'h00001);
    check_read("s4_pre", 4'd2);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_din = 18'h3FFFF;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    sweep_check("s4_sweep", 1'b0);
    check_read("s4_a2", 4'd2);
    chk("s4_a2_const", rd_dout, CV);

    // Scenario 5: rst at sweep count 9 restarts a full-length sweep.
    do_write(4'd9, 18'h15555);
    pulse_rst();
    repeat (9) tick();
    chk("s5_mid_ready", {{(DW-1){1'b0}}, ready}, '0);
    pulse_rst();
    sweep_check("s5_restart", 1'b1);
    for (int a = 0; a < DEPTH; a++) check_read("s5_clear", AW'(a));

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      do_write(AW'($urandom), DW'($urandom));
      check_read("rand", AW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bram_dp_clr

// File: doc/bram_dp_clr.md
Name: bram_dp_clr

Overview:
Parametrised simple-dual-port RAM for NTT coefficient storage: one write port with write-side readback, and one independent read port.
- Addresses are registered, as in the existing fixed 18x2048 RAMs.
- Adds a built-in clear engine that sweeps every word to a constant after reset or on request, plus a ready flag.
- Sits between the NTT butterfly datapath and its address generators; it is the generalised replacement for the fixed-width/depth RAM instances.

Parameters:
DW, 18, data width in bits
AW, 11, address width; depth is 2**AW words
CLEAR_VAL, 0, DW-bit value written to every word during a clear sweep

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset; starts a clear sweep
clr  in  1  single-cycle request to re-clear the whole RAM; honoured only when ready=1
wr_en  in  1  write enable; ignored while ready=0
wr_addr  in  AW  write address; also the readback address for wr_dout
rd_addr  in  AW  read address
wr_din  in  DW  write data
wr_dout  out  DW  data at the registered wr_addr
rd_dout  out  DW  data at the registered rd_addr
ready  out  1  high when the RAM is accepting user traffic (no sweep in progress)

Behaviour:
- Clock is clk; reset is synchronous, active-high, named rst.
- Reset state:
  - state=CLEAR, sweep counter cnt=0, ready=0.
  - Both address registers = 0.
  - wr_dout=rd_dout=0.
  - RAM contents are not reset directly; the sweep overwrites them.
- FSM has two states, CLEAR and READY.
  - CLEAR, each edge: ram[cnt] <= CLEAR_VAL; cnt <= cnt+1. On the edge that writes cnt=2**AW-1, go to READY and set ready=1.
  - READY: normal operation. clr=1 at an edge gives cnt<=0, state<=CLEAR, ready<=0.
  - Sweep length is exactly 2**AW edges. ready rises after the 2**AW-th edge following rst deassertion.
- rst asserted mid-sweep restarts the sweep at cnt=0. rst has priority over clr.
- clr while in CLEAR is ignored (no restart).
- clr and wr_en in the same READY cycle: clr wins and the user write is dropped.
- While ready=0:
  - user wr_en is masked.
  - wr_dout and rd_dout are forced to 0.
  - Address registers still track wr_addr and rd_addr every cycle.
- Normal write: if wr_en and ready, ram[wr_addr] <= wr_din at the edge.
- Read latency is 1 cycle. Address registers load every edge, and outputs are ram[reg_addr] combinationally after that edge.
- Same-address write and read in one cycle is write-first. At cycle t+1, rd_dout and wr_dout show wr_din(t).
- wr_dout shows the new data one cycle after a write to the same address (write readback).
- Address space is exactly 2**AW. There is no out-of-range condition and no wrap logic beyond natural AW-bit rollover of cnt.
- Widths: no arithmetic on data; cnt is AW bits plus terminal detect on all-ones.

Optional Feature:
Macro BRAM_DP_OUTREG_EN.
- Defined: wr_dout and rd_dout each pass through one extra output register.
  - Read latency becomes 2 cycles.
  - The registers reset to 0 on rst and are forced to 0 while ready=0 (registered from the masked value).
  - Write-first semantics hold, shifted by one cycle.
- Undefined: latency 1 as above, with no output registers.

Decomposition:
- Package bram_pkg:
  - state enum {ST_CLEAR, ST_READY}.
  - default constants BRAM_DW=18 and BRAM_AW=11.
- One natural sub-module, bram_clr_ctrl. It holds the FSM, the sweep counter and ready, and produces the muxed write port:
  - eff_we = state==CLEAR ? 1 : wr_en&&!clr
  - eff_addr = CLEAR ? cnt : wr_addr
  - eff_din = CLEAR ? CLEAR_VAL : wr_din
- The top level keeps the storage array, address registers and output masking.

Test Plan:
1. AW=4, DW=18, CLEAR_VAL=18'h2AAAA, RAM preloaded with random data.
   - Stimulus: pulse rst 1 cycle.
   - Required: ready=0 for exactly 16 edges, then 1. Every address reads 18'h2AAAA. Outputs are 0 while ready=0.
2. After ready, write addr 3 = 18'h12345 and addr 7 = 18'h3FFFF.
   - Stimulus: read rd_addr=3, then 7.
   - Required: rd_dout=18'h12345 and 18'h3FFFF, each 1 cycle after the address.
3. In one cycle, write addr 5 = 18'h00ABC with rd_addr=5.
   - Required: next cycle rd_dout=18'h00ABC and wr_dout=18'h00ABC (write-first).
4. READY state, addr 2 holds 18'h00001.
   - Stimulus: assert clr together with wr_en to addr 2 = 18'h3FFFF.
   - Required: write dropped, ready low for 16 edges, then addr 2 reads CLEAR_VAL.
5. Assert rst at sweep cnt=9.
   - Required: sweep restarts. ready rises 16 edges after rst release, not 7. clr during the sweep does not extend it.
6. With BRAM_DP_OUTREG_EN defined, repeat scenario 2.
   - Required: data appears 2 cycles after the address; outputs 0 during the sweep and on reset.
